// File: rtl/ram_arbiter32x4_pkg.sv
// Shared sizing constants and state encodings for the ram_arbiter32x4 block.
package ram_arbiter32x4_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } requester_t;

endpackage

// File: rtl/ram_arbiter32x4_ram32x4.sv
// 32x4 single-port synchronous RAM: write and registered read share one address per cycle.
module ram32x4
    import ram_arbiter32x4_pkg::*;
(
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM macros; initial contents come from the clear engine.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/ram_arbiter32x4.sv
// Two-requester round-robin arbiter in front of a shared 32x4 RAM.
// Define RAM_ARB_CLEAR_EN to write CLEAR_VALUE to every word after each reset.
module ram_arbiter32x4
    import ram_arbiter32x4_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 4'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_req,
    input  logic              b_wren,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              a_grant,
    output logic              b_grant,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    logic              clearing;
    requester_t        last_grant;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    // On a tie the requester that did not win last time gets the RAM.
    assign a_grant = ~busy & a_req & (~b_req | (last_grant == REQ_B));
    assign b_grant = ~busy & b_req & (~a_req | (last_grant == REQ_A));

    // A reset landing on the response cycle swallows the pending pulse.
    assign a_rvalid = a_rvalid_q & ~reset;
    assign b_rvalid = b_rvalid_q & ~reset;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= REQ_B;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_grant & ~a_wren;
            b_rvalid_q <= b_grant & ~b_wren;
            if (a_grant) begin
                last_grant <= REQ_A;
            end else if (b_grant) begin
                last_grant <= REQ_B;
            end
        end
    end

`ifdef RAM_ARB_CLEAR_EN
    state_t            state;
    logic [ADDR_W-1:0] clear_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clear_addr <= clear_addr + 1'b1;
            if (clear_addr == ADDR_W'(DEPTH - 1)) begin
                state <= ST_ARB;
            end
        end
    end

    assign clearing = (state == ST_CLEAR);
    assign busy     = reset | clearing;
`else
    assign clearing = 1'b0;
    assign busy     = reset;
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        ram_wren = 1'b0;
        ram_addr = a_addr;
        ram_data = CLEAR_VALUE;
        if (a_grant) begin
            ram_wren = a_wren;
            ram_data = a_data;
        end else if (b_grant) begin
            ram_wren = b_wren;
            ram_addr = b_addr;
            ram_data = b_data;
        end
`ifdef RAM_ARB_CLEAR_EN
        if (clearing && !reset) begin
            ram_wren = 1'b1;
            ram_addr = clear_addr;
            ram_data = CLEAR_VALUE;
        end
`endif
    end

    ram32x4 u_ram (
        .address (ram_addr),
        .clock   (clock),
        .data    (ram_data),
        .wren    (ram_wren),
        .q       (rdata)
    );

endmodule

// File: tb/tb_ram_arbiter32x4.sv
// Self-checking bench for ram_arbiter32x4; follows RAM_ARB_CLEAR_EN the same way the RTL does.
module tb_ram_arbiter32x4;

`ifdef RAM_ARB_CLEAR_EN
    localparam int CLR = 32;
`else
    localparam int CLR = 0;
`endif
    localparam logic [3:0] CV = 4'h0;

    logic       clock;
    logic       reset;
    logic       a_req, a_wren, b_req, b_wren;
    logic [4:0] a_addr, b_addr;
    logic [3:0] a_data, b_data;
    logic       a_grant, b_grant, a_rvalid, b_rvalid, busy;
    logic [3:0] rdata;

    int errors = 0;
    int checks = 0;

    ram_arbiter32x4 #(.CLEAR_VALUE(CV)) dut (
        .clock    (clock),
        .reset    (reset),
        .a_req    (a_req),
        .a_wren   (a_wren),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_req    (b_req),
        .b_wren   (b_wren),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .a_grant  (a_grant),
        .b_grant  (b_grant),
        .a_rvalid (a_rvalid),
        .b_rvalid (b_rvalid),
        .rdata    (rdata),
        .busy     (busy)
    );

    // Negedge comes first so the model sees the opening reset cycle.
    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: busy for CLR cycles after reset, round-robin on ties,
    // a read answers one cycle later with the word the model last stored.
    logic [3:0] m_mem [32];
    bit  [31:0] m_known  = '0;
    int         m_since  = 0;
    bit         m_last_b = 1'b1;
    bit         m_pa     = 1'b0;
    bit         m_pb     = 1'b0;
    logic [3:0] m_pdata  = '0;
    bit         m_pknown = 1'b0;

    always @(negedge clock) begin
        bit eb, eag, ebg, earv, ebrv;
        eb   = reset || (m_since < CLR);
        eag  = !eb && a_req && (!b_req || m_last_b);
        ebg  = !eb && b_req && !eag;
        earv = m_pa && !reset;
        ebrv = m_pb && !reset;
        check("busy", busy, eb);
        check("a_grant", a_grant, eag);
        check("b_grant", b_grant, ebg);
        check("a_rvalid", a_rvalid, earv);
        check("b_rvalid", b_rvalid, ebrv);
        if ((earv || ebrv) && m_pknown) check("rdata", rdata, m_pdata);

        if (reset) begin
            m_since  = 0;
            m_last_b = 1'b1;
            m_pa     = 1'b0;
            m_pb     = 1'b0;
`ifndef RAM_ARB_CLEAR_EN
            m_known  = '0;
`endif
        end else begin
            if (m_since < CLR) begin
                m_mem[m_since]   = CV;
                m_known[m_since] = 1'b1;
            end
            if (m_since < 1000) m_since++;
            m_pa = eag && !a_wren;
            m_pb = ebg && !b_wren;
            if (eag) begin
                if (a_wren) begin
                    m_mem[a_addr] = a_data;
                    m_known[a_addr] = 1'b1;
                end else begin
                    m_pdata = m_mem[a_addr];
                    m_pknown = m_known[a_addr];
                end
                m_last_b = 1'b0;
            end else if (ebg) begin
                if (b_wren) begin
                    m_mem[b_addr] = b_data;
                    m_known[b_addr] = 1'b1;
                end else begin
                    m_pdata = m_mem[b_addr];
                    m_pknown = m_known[b_addr];
                end
                m_last_b = 1'b1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_wren = 0; a_addr = '0; a_data = '0;
        b_req = 0; b_wren = 0; b_addr = '0; b_data = '0;
    endtask

    // Counts busy cycles from the current one; stops after the first idle cycle or a bound.
    task automatic count_busy(output int n);
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            if (busy) n++;
            else done = 1;
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [5:0] ga, gb;
        idle_inputs();
        reset = 1;
        a_req = 1;                      // ignored while in reset
        next_cycle();
        a_req = 0;
        reset = 0;
        count_busy(n);
        check("busy_len_after_reset", n, CLR);

        // Back-to-back reads of the cleared image.
        a_req = 1; a_wren = 0; a_addr = 5'd0;  next_cycle();
        a_addr = 5'd17; next_cycle();
        a_addr = 5'd31; next_cycle();
        a_req = 0;
        @(negedge clock);
        check("rd31_rvalid", a_rvalid, 1'b1);
`ifdef RAM_ARB_CLEAR_EN
        check("rd31_clear_value", rdata, 4'h0);
`endif
        next_cycle();

        // A writes 4'hA to 5, then reads it back.
        a_req = 1; a_wren = 1; a_addr = 5'd5; a_data = 4'hA;
        @(negedge clock); check("a_wr_grant", a_grant, 1'b1);
        next_cycle();
        a_wren = 0;
        @(negedge clock); check("a_rd_grant", a_grant, 1'b1);
        next_cycle();
        a_req = 0;
        @(negedge clock);
        check("a_rd_rvalid", a_rvalid, 1'b1);
        check("a_rd_data", rdata, 4'hA);
        check("a_rd_b_rvalid", b_rvalid, 1'b0);
        next_cycle();

        // B writes 4'h3 to 9; A reads 9 right after.
        b_req = 1; b_wren = 1; b_addr = 5'd9; b_data = 4'h3; next_cycle();
        b_req = 0; a_req = 1; a_wren = 0; a_addr = 5'd9; next_cycle();
        a_req = 0;
        @(negedge clock);
        check("raw_rvalid", a_rvalid, 1'b1);
        check("raw_data", rdata, 4'h3);
        next_cycle();

        // A lone B read leaves B as last winner, so the next tie goes to A.
        b_req = 1; b_wren = 0; b_addr = 5'd9; next_cycle();
        b_req = 0;
        @(negedge clock);
        check("b_rd_rvalid", b_rvalid, 1'b1);
        check("b_rd_data", rdata, 4'h3);
        next_cycle();

        // Both request reads for six cycles.
        a_req = 1; a_wren = 0; a_addr = 5'd5;
        b_req = 1; b_wren = 0; b_addr = 5'd9;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ga[5-i] = a_grant;
            gb[5-i] = b_grant;
            next_cycle();
        end
        a_req = 0; b_req = 0;
        check("rr_a_sequence", ga, 6'b101010);
        check("rr_b_sequence", gb, 6'b010101);
        next_cycle();

        // Read granted in N, reset in N+1: no rvalid.
        a_req = 1; a_wren = 0; a_addr = 5'd5; next_cycle();
        a_req = 0; reset = 1;
        @(negedge clock);
        check("abort_rvalid", a_rvalid, 1'b0);
        next_cycle();
        reset = 0;
        count_busy(n);
        check("busy_len_after_abort", n, CLR);

        // Dirty word 31, then reset again partway through the clear.
        a_req = 1; a_wren = 1; a_addr = 5'd31; a_data = 4'h7; next_cycle();
        a_req = 0; a_wren = 0;
        reset = 1; next_cycle();
        reset = 0;
        for (int i = 0; i < 10; i++) next_cycle();
        reset = 1; next_cycle();
        reset = 0;
        count_busy(n);
        check("busy_len_after_midclear_reset", n, CLR);
        a_req = 1; a_wren = 0; a_addr = 5'd31; next_cycle();
        a_req = 0;
        @(negedge clock);
        check("rd31_after_restart_rvalid", a_rvalid, 1'b1);
`ifdef RAM_ARB_CLEAR_EN
        check("rd31_after_restart_data", rdata, 4'h0);
`endif
        next_cycle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter32x4.md
RAM_ARBITER32X4 -- requirements
Module: ram_arbiter32x4

Interface
REQ-001 SHALL have parameter: CLEAR_VALUE, 4'h0, word written to every address by the clear engine.
REQ-002 SHALL have port: clock  in  1  rising-edge clock for all state and the RAM.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: a_req / b_req  in  1  access request, held until granted.
REQ-005 SHALL have ports: a_wren / b_wren  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports: a_addr / b_addr  in  5  word address 0..31.
REQ-007 SHALL have ports: a_data / b_data  in  4  write data.
REQ-008 SHALL have ports: a_grant / b_grant  out  1  access accepted this cycle (combinational).
REQ-009 SHALL have ports: a_rvalid / b_rvalid  out  1  one-cycle pulse; rdata holds that requester's read result.
REQ-010 SHALL have port: rdata  out  4  RAM read data.
REQ-011 SHALL have port: busy  out  1  clear engine active; no grants.

Function
REQ-012 SHALL be a two-state FSM: CLEAR and ARB.
REQ-013 CLEAR SHALL write CLEAR_VALUE to addresses 0,1,...,31, one per cycle, using a 5-bit counter.
REQ-014 Exit: after address 31 is written, go to ARB the next cycle (CLEAR lasts exactly 32 cycles); counter wrap 31->0 SHALL NOT restart the clear.
REQ-015 busy SHALL be 1 exactly in CLEAR; a_grant = b_grant = 0 while busy, requests ignored, not queued.
REQ-016 In ARB, a single requester SHALL be granted in the same cycle it asserts req.
REQ-017 When both request, the one not granted most recently SHALL win (round-robin); loser's grant = 0 and it keeps req high.
REQ-018 At most one grant per cycle; last-granted pointer SHALL update only on a grant.
REQ-019 Granted request's wren/addr/data SHALL drive the RAM in the grant cycle; idle cycles SHALL drive wren = 0.
REQ-020 Read latency: for a granted read in cycle N, that requester's rvalid SHALL pulse in cycle N+1, with rdata = word at addr.
REQ-021 Writes SHALL produce no rvalid; a read granted the cycle after a write to the same address SHALL return the new data.
REQ-022 Back-to-back grants (every cycle, alternating or same requester) SHALL be supported with no bubble.

Reset
REQ-023 reset SHALL force state CLEAR, clear counter = 0, last-granted pointer = B (A wins the first tie), a_rvalid = b_rvalid = 0.
REQ-024 While reset is high: busy = 1, grants = 0, RAM wren = 0; the clear starts at address 0 in the first cycle after reset falls.
REQ-025 Reset asserted mid-clear or mid-access SHALL abort it; a pending rvalid SHALL be suppressed; the clear restarts at address 0.

Configuration
REQ-026 Macro RAM_ARB_CLEAR_EN defined: CLEAR behaviour as in REQ-013..015.
REQ-027 Macro RAM_ARB_CLEAR_EN undefined: no CLEAR state or counter; reset goes straight to ARB; busy is tied to 0 except during reset; RAM contents are undefined after reset.

Structure
REQ-028 A shared package SHALL hold ADDR_W = 5, DATA_W = 4, DEPTH = 32 and the state encoding (CLEAR, ARB).
REQ-029 SHALL instantiate exactly one sub-module, ram32x4 (address, clock, data, wren, q), as the shared storage.

Verification
REQ-030 Reset 1 cycle, then release -> busy = 1 for 32 cycles, then 0; reading addresses 0, 17 and 31 returns 4'h0.
REQ-031 A writes 4'hA to address 5, then reads address 5 -> a_grant in each cycle; a_rvalid the next cycle with rdata = 4'hA; b_rvalid stays 0.
REQ-032 Both request continuously for 6 cycles after clear -> grants go A, B, A, B, A, B.
REQ-033 B write 4'h3 to address 9, then A read of address 9 the next cycle -> a_rvalid with rdata = 4'h3.
REQ-034 Reset pulsed at clear cycle 10 -> busy stays high for 32 further cycles; address 31 reads CLEAR_VALUE.
REQ-035 A read granted, reset in cycle N+1 -> a_rvalid = 0.
